// File: rtl/lcd_fetch_pkg.sv
// Shared definitions for the LCD pixel fetch path: pixel word layout, burst-count width and FSM codes.
package lcd_fetch_pkg;
  localparam int R_LSB  = 16;
  localparam int G_LSB  = 8;
  localparam int B_LSB  = 0;
  localparam int BCNT_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  function automatic pixel_t unpackPixel(input logic [31:0] word);
    pixel_t p;
    p.red   = word[R_LSB +: 8];
    p.green = word[G_LSB +: 8];
    p.blue  = word[B_LSB +: 8];
    return p;
  endfunction
endpackage

// File: rtl/lcd_fetch_fifo.sv
// First-word fall-through pixel FIFO: head is visible on oData with zero latency; flush empties it in one cycle.
module lcd_fetch_fifo
  import lcd_fetch_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iFlush,
  input  logic                   iPush,
  input  pixel_t                 iData,
  input  logic                   iPop,
  output pixel_t                 oData,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oFull,
  output logic                   oEmpty
);
  localparam int AW = $clog2(DEPTH);

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          doPush, doPop;

  assign oFull  = oCount == (AW+1)'(DEPTH);
  assign oEmpty = oCount == '0;
  assign oData  = mem[rdPtr];
  // flush wins over everything queued in the same cycle
  assign doPop  = iPop && !oEmpty && !iFlush;
  assign doPush = iPush && !oFull && !iFlush;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oCount <= '0;
    end else if (iFlush) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oCount <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      oCount <= oCount + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  always_ff @(posedge iCLK) begin
    if (doPush) mem[wrPtr] <= iData;
  end
endmodule

// File: rtl/lcd_pixel_fetch.sv
// Framebuffer prefetch for the LCD timing generator: burst reads into a FWFT FIFO, resync on top-of-screen.
// Optional LCD_FETCH_UNDERFLOW_CNT_EN adds a saturating underflow event counter (oUnderflowCount).
module lcd_pixel_fetch
  import lcd_fetch_pkg::*;
#(
  parameter int H_ACT      = 800,
  parameter int V_ACT      = 480,
  parameter int FIFO_DEPTH = 256,
  parameter int BURST_LEN  = 16,
  parameter int ADDR_W     = 24
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] iBase,
  input  logic              iTopOfScreen,
  input  logic              iRequest,
  output logic [7:0]        oRed,
  output logic [7:0]        oGreen,
  output logic [7:0]        oBlue,
  output logic              oMemRead,
  output logic [ADDR_W-1:0] oMemAddress,
  output logic [BCNT_W-1:0] oMemBurstCount,
  input  logic              iMemWaitRequest,
  input  logic [31:0]       iMemReadData,
  input  logic              iMemReadDataValid,
  output logic              oUnderflow
`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       oUnderflowCount
`endif
);
  localparam int FRAME = H_ACT * V_ACT;
  localparam int REM_W = $clog2(FRAME + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    BL     = CW'(BURST_LEN);
  localparam logic [CW:0]      RESV   = (CW+1)'(FIFO_DEPTH - BURST_LEN);
  localparam logic [REM_W-1:0] REM_BL = REM_W'(BURST_LEN);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [REM_W-1:0]  remain;
  logic [CW-1:0]     outst, discard, occ, flushSum;
  logic              staleCmd, full, empty;
  logic              accept, drop, push, pop, issue;
  pixel_t            head;

  assign oMemBurstCount = BCNT_W'(BURST_LEN);
  assign accept = oMemRead && !iMemWaitRequest;
  // a beat landing on the flush cycle belongs to the old frame
  assign drop   = iMemReadDataValid && (iTopOfScreen || discard != '0);
  assign push   = iMemReadDataValid && !drop;
  assign pop    = iRequest && !empty;
  // one command in flight at a time; reservation covers FIFO contents plus beats still owed
  assign issue  = state == RUN && !oMemRead && !iTopOfScreen && remain != '0 &&
                  ({1'b0, occ} + {1'b0, outst}) <= RESV;
  assign flushSum = discard + outst + (accept ? BL : '0);
  assign {oRed, oGreen, oBlue} = empty ? 24'd0 : head;

  lcd_fetch_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iFlush (iTopOfScreen),
    .iPush  (push),
    .iData  (unpackPixel(iMemReadData)),
    .iPop   (pop),
    .oData  (head),
    .oCount (occ),
    .oFull  (full),
    .oEmpty (empty)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= IDLE;
      addr        <= '0;
      remain      <= '0;
      outst       <= '0;
      discard     <= '0;
      staleCmd    <= 1'b0;
      oMemRead    <= 1'b0;
      oMemAddress <= '0;
    end else begin
      if (accept) begin
        oMemRead <= 1'b0;
      end else if (issue) begin
        oMemRead    <= 1'b1;
        oMemAddress <= addr;
      end

      if (iTopOfScreen) begin
        state    <= RUN;
        addr     <= iBase;
        remain   <= REM_W'(FRAME);
        outst    <= '0;
        discard  <= flushSum - CW'(iMemReadDataValid && flushSum != '0);
        // a held command survives the flush; its beats must be thrown away
        staleCmd <= oMemRead && !accept;
      end else begin
        if (accept && !staleCmd) begin
          addr   <= addr + ADDR_W'(BURST_LEN);
          remain <= (remain > REM_BL) ? remain - REM_BL : '0;
          if (remain <= REM_BL) state <= DONE;
        end
        if (accept) staleCmd <= 1'b0;
        outst   <= outst + ((accept && !staleCmd) ? BL : '0) - CW'(push);
        discard <= discard + ((accept && staleCmd) ? BL : '0) - CW'(drop);
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                   oUnderflow <= 1'b0;
    else if (iRequest && empty) oUnderflow <= 1'b1;
  end

`ifdef LCD_FETCH_UNDERFLOW_CNT_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                                           oUnderflowCount <= '0;
    else if (iRequest && empty && oUnderflowCount != 16'hFFFF) oUnderflowCount <= oUnderflowCount + 16'd1;
  end
`endif

  noOverflow: assert property (@(posedge iCLK) disable iff (iRST) !(push && full && !iTopOfScreen));
endmodule
